store_writedata: RTL and testbench

- Store-side counterpart of the load-data extraction path in the memory stage.
- Accepts one store at a time from the memory stage and performs the alignment check.
- Places the store data onto the correct byte lanes of the 64-bit data bus and generates the byte strobe.
- Drives the dbus request and holds it until the response arrives, then reports completion or error back to the pipeline.

---
 rtl/store_writedata.sv | 119 +++++++++++
 tb/tb_store_writedata.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_writedata.sv
// Store write-data path: alignment check, byte-lane placement and strobe, dbus request held until data_ok.
// Latency: dreq_valid the cycle after acceptance; done pulse the cycle after data_ok (or after acceptance on a fault).
module store_writedata #(
    parameter int unsigned BUS_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_data,
    input  logic [2:0]  in_msize,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [2:0]  dreq_size,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    output logic        done_valid,
    output logic        done_error,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t      state, state_nxt;
    logic [63:0] addr_q, data_q;
    logic [2:0]  size_q;
    logic [7:0]  strobe_q;
    logic [31:0] tmo_cnt;

    logic        legal, aligned, tmo_hit;
    logic [7:0]  base;
    logic [63:0] mask, lane_data;
    logic [7:0]  lane_strobe;

    // The bus address handshake carries no obligation here; the request is held until data_ok.
    logic unused_addr_ok;
    assign unused_addr_ok = dresp_addr_ok;

    always_comb begin
        legal   = 1'b1;
        aligned = 1'b0;
        base    = 8'h00;
        mask    = 64'h0;
        case (in_msize)
            3'd0: begin base = 8'h01; mask = 64'h0000_0000_0000_00FF; aligned = 1'b1; end
            3'd1: begin base = 8'h03; mask = 64'h0000_0000_0000_FFFF; aligned = ~in_addr[0]; end
            3'd2: begin base = 8'h0F; mask = 64'h0000_0000_FFFF_FFFF; aligned = (in_addr[1:0] == 2'b00); end
            3'd3: begin base = 8'hFF; mask = 64'hFFFF_FFFF_FFFF_FFFF; aligned = (in_addr[2:0] == 3'b000); end
            default: legal = 1'b0;
        endcase
        lane_data   = (in_data & mask) << {in_addr[2:0], 3'b000};
        lane_strobe = base << in_addr[2:0];
    end

    always_comb begin
        tmo_hit = (BUS_TIMEOUT != 0) && (tmo_cnt == BUS_TIMEOUT - 32'd1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = (legal && aligned) ? REQ : ERR;
            // data_ok wins over a timeout landing on the same cycle
            REQ: begin
                if (dresp_data_ok)  state_nxt = DONE;
                else if (tmo_hit)   state_nxt = ERR;
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= 64'h0;
            data_q   <= 64'h0;
            size_q   <= 3'd0;
            strobe_q <= 8'h00;
            tmo_cnt  <= 32'd0;
        end else begin
            if (state == IDLE) begin
                tmo_cnt <= 32'd0;
                if (in_valid) begin
                    addr_q   <= {in_addr[63:3], 3'b000};
                    data_q   <= lane_data;
                    size_q   <= in_msize;
                    strobe_q <= lane_strobe;
                end
            end else if (state == REQ && !dresp_data_ok) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        dreq_valid  = (state == REQ);
        dreq_addr   = dreq_valid ? addr_q   : 64'h0;
        dreq_size   = dreq_valid ? size_q   : 3'd0;
        dreq_strobe = dreq_valid ? strobe_q : 8'h00;
        dreq_data   = dreq_valid ? data_q   : 64'h0;
        in_ready    = (state == IDLE);
        busy        = (state != IDLE);
        done_valid  = (state == DONE) || (state == ERR);
        done_error  = (state == ERR);
    end

endmodule

// File: tb/tb_store_writedata.sv
// Directed bench for store_writedata: a byte-lane model feeds a scoreboard queue that is checked on dreq and done.
module tb_store_writedata;

    localparam int TO = 4;

    typedef struct packed {
        logic        req;
        logic        err;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid_a = 1'b0, in_valid_b = 1'b0, sel_b = 1'b0;
    logic [63:0] in_addr = '0, in_data = '0;
    logic [2:0]  in_msize = '0;
    logic        dresp_addr_ok = 1'b0, dresp_data_ok = 1'b0;

    logic        a_in_ready, a_dreq_valid, a_done_valid, a_done_error, a_busy;
    logic [63:0] a_dreq_addr, a_dreq_data;
    logic [2:0]  a_dreq_size;
    logic [7:0]  a_dreq_strobe;
    logic        b_in_ready, b_dreq_valid, b_done_valid, b_done_error, b_busy;
    logic [63:0] b_dreq_addr, b_dreq_data;
    logic [2:0]  b_dreq_size;
    logic [7:0]  b_dreq_strobe;

    logic        o_in_ready, o_dreq_valid, o_done_valid, o_done_error, o_busy;
    logic [63:0] o_dreq_addr, o_dreq_data;
    logic [2:0]  o_dreq_size;
    logic [7:0]  o_dreq_strobe;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    store_writedata #(.BUS_TIMEOUT(0)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(a_in_ready),
        .in_addr(in_addr), .in_data(in_data), .in_msize(in_msize),
        .dreq_valid(a_dreq_valid), .dreq_addr(a_dreq_addr), .dreq_size(a_dreq_size),
        .dreq_strobe(a_dreq_strobe), .dreq_data(a_dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .done_valid(a_done_valid), .done_error(a_done_error), .busy(a_busy)
    );

    store_writedata #(.BUS_TIMEOUT(TO)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(b_in_ready),
        .in_addr(in_addr), .in_data(in_data), .in_msize(in_msize),
        .dreq_valid(b_dreq_valid), .dreq_addr(b_dreq_addr), .dreq_size(b_dreq_size),
        .dreq_strobe(b_dreq_strobe), .dreq_data(b_dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .done_valid(b_done_valid), .done_error(b_done_error), .busy(b_busy)
    );

    assign o_in_ready    = sel_b ? b_in_ready    : a_in_ready;
    assign o_dreq_valid  = sel_b ? b_dreq_valid  : a_dreq_valid;
    assign o_dreq_addr   = sel_b ? b_dreq_addr   : a_dreq_addr;
    assign o_dreq_size   = sel_b ? b_dreq_size   : a_dreq_size;
    assign o_dreq_strobe = sel_b ? b_dreq_strobe : a_dreq_strobe;
    assign o_dreq_data   = sel_b ? b_dreq_data   : a_dreq_data;
    assign o_done_valid  = sel_b ? b_done_valid  : a_done_valid;
    assign o_done_error  = sel_b ? b_done_error  : a_done_error;
    assign o_busy        = sel_b ? b_busy        : a_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Byte-by-byte reference: store byte j lands on lane off+j for j < size in bytes.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] d,
                                   input logic [2:0] sz, input bit no_resp);
        exp_t e;
        int   nb;
        int   off;
        e    = '0;
        nb   = 0;
        off  = int'(a[2:0]);
        e.addr = a & ~64'h7;
        e.size = sz;
        if (sz > 3'd3) begin
            e.req = 1'b0;
        end else begin
            nb    = 1 << sz;
            e.req = ((off % nb) == 0);
        end
        e.err = !e.req || no_resp;
        if (e.req) begin
            for (int i = 0; i < 8; i++) begin
                if (i >= off && i < off + nb) begin
                    e.strobe[i]      = 1'b1;
                    e.data[8*i +: 8] = d[8*(i-off) +: 8];
                end
            end
        end
        return e;
    endfunction

    task automatic set_valid(input bit use_b, input logic v);
        in_valid_a = use_b ? 1'b0 : v;
        in_valid_b = use_b ? v : 1'b0;
    endtask

    // dok: REQ cycle index (0-based) carrying data_ok; negative means never.
    task automatic run_store(input bit use_b, input logic [63:0] a, input logic [63:0] d,
                             input logic [2:0] sz, input int aok, input int dok, input bit hold);
        exp_t e;
        exp_t got;
        int   nreq;
        e = model(a, d, sz, dok < 0);
        sb.push_back(e);
        sel_b    = use_b;
        in_addr  = a;
        in_data  = d;
        in_msize = sz;
        set_valid(use_b, 1'b1);
        @(posedge clk); #1;
        if (e.req) begin
            nreq = (dok < 0) ? TO : dok + 1;
            for (int c = 0; c < nreq; c++) begin
                if (c > 0) begin @(posedge clk); #1; end
                set_valid(use_b, hold);
                if (hold && c > 0) begin
                    in_addr = ~a;
                    in_data = ~d;
                end
                dresp_addr_ok = (c == aok);
                dresp_data_ok = (c == dok);
                @(negedge clk);
                chk("req_valid",  o_dreq_valid, 1);
                chk("req_ready",  o_in_ready, 0);
                chk("req_addr",   o_dreq_addr, sb[0].addr);
                chk("req_size",   o_dreq_size, sb[0].size);
                chk("req_strobe", o_dreq_strobe, sb[0].strobe);
                chk("req_data",   o_dreq_data, sb[0].data);
            end
            @(posedge clk); #1;
        end
        set_valid(use_b, 1'b0);
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        @(negedge clk);
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
            got = sb.pop_front();
            chk("done_error", o_done_error, got.err);
        end
        chk("done_valid", o_done_valid, 1);
        chk("done_dreq_low", o_dreq_valid, 0);
        chk("done_ready", o_in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("idle_done_low", o_done_valid, 0);
        chk("idle_ready", o_in_ready, 1);
        chk("idle_busy", o_busy, 0);
        chk("idle_dreq_low", o_dreq_valid, 0);
    endtask

    initial begin
        #3;
        chk("rst_ready", a_in_ready, 1);
        chk("rst_dreq_valid", a_dreq_valid, 0);
        chk("rst_dreq_addr", a_dreq_addr, 0);
        chk("rst_dreq_size", a_dreq_size, 0);
        chk("rst_dreq_strobe", a_dreq_strobe, 0);
        chk("rst_dreq_data", a_dreq_data, 0);
        chk("rst_done", {a_done_valid, a_done_error}, 0);
        chk("rst_busy", a_busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);

        run_store(0, 64'h1003, 64'hFFAB, 3'd0, -1, 1, 0);
        run_store(0, 64'h6, 64'h1234, 3'd1, -1, 0, 0);
        run_store(0, 64'h8, 64'h0123_4567_89AB_CDEF, 3'd3, -1, 0, 0);
        run_store(0, 64'hC, 64'hDEAD_BEEF_CAFE_F00D, 3'd2, 0, 0, 0);
        run_store(0, 64'h2, 64'h5555_6666, 3'd2, -1, 0, 0);
        run_store(0, 64'h5, 64'h7777, 3'd1, -1, 0, 0);
        run_store(0, 64'h10, 64'h1, 3'd5, -1, 0, 0);
        run_store(0, 64'h20, 64'hA5A5_5A5A_0F0F_F0F0, 3'd3, 1, 4, 1);

        run_store(1, 64'h10, 64'h0BAD_F00D, 3'd2, -1, -1, 0);
        run_store(1, 64'h14, 64'h0BAD_F00D, 3'd2, -1, 3, 0);

        // reset while a request is outstanding
        sel_b    = 1'b0;
        in_addr  = 64'h40;
        in_data  = 64'h1122_3344_5566_7788;
        in_msize = 3'd3;
        in_valid_a = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", a_dreq_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_dreq", a_dreq_valid, 0);
        chk("mid_rst_busy", a_busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_no_done", a_done_valid, 0);
        end
        run_store(0, 64'h48, 64'h99, 3'd0, -1, 2, 0);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
